// File: rtl/vend_credit_sequencer_if.sv
// rtl/vend_credit_sequencer_if.sv - coin/vend/dispense signal bundle for the credit sequencer
interface vend_credit_sequencer_if;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       vend_req;
    logic       cancel;
    logic       disp_ack;
    logic [3:0] credit_state;
    logic       dispense;
    logic       change_pulse;
    logic       coin_reject;
    logic       fault;
    logic       busy;

    modport master (
        output coin_valid, coin_value, vend_req, cancel, disp_ack,
        input  credit_state, dispense, change_pulse, coin_reject, fault, busy
    );

    modport slave (
        input  coin_valid, coin_value, vend_req, cancel, disp_ack,
        output credit_state, dispense, change_pulse, coin_reject, fault, busy
    );
endinterface

// File: rtl/vend_credit_sequencer.sv
// rtl/vend_credit_sequencer.sv - vending credit FSM: coin accumulation, vend/cancel, dispense handshake, change payout
module vend_credit_sequencer #(
    parameter int PRICE       = 3,
    parameter int MAX_CREDIT  = 15,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    vend_credit_sequencer_if.slave        bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COLLECT  = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_CHANGE   = 2'd3;

    localparam logic [4:0] PRICE5   = 5'(PRICE);
    localparam logic [4:0] MAX5     = 5'(MAX_CREDIT);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic [7:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic       dispense_q, dispense_d;
    logic       change_q, change_d;
    logic       reject_q, reject_d;
    logic       fault_q, fault_d;
    logic       busy_q, busy_d;

    logic [4:0] coin_units;
    logic [4:0] coin_sum;
    logic       coin_ok;

    always_comb begin
        case (bus.coin_value)
            2'b01:   coin_units = 5'd1;
            2'b10:   coin_units = 5'd2;
            2'b11:   coin_units = 5'd5;
            default: coin_units = 5'd0;
        endcase
    end

    // Sum is formed one bit wider so a coin that would overflow is refused, never wrapped.
    assign coin_sum = {1'b0, credit_q} + coin_units;
    assign coin_ok  = (coin_units != 5'd0) && (coin_sum <= MAX5);

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        cnt_d      = cnt_q;
        phase_d    = 1'b0;
        dispense_d = dispense_q;
        change_d   = 1'b0;
        reject_d   = 1'b0;
        fault_d    = 1'b0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if ((state_q == S_COLLECT) && bus.cancel) begin
                    state_d  = S_CHANGE;
                    reject_d = bus.coin_valid;
                end else if (bus.coin_valid) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[3:0];
                        state_d  = S_COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if ((state_q == S_COLLECT) && bus.vend_req
                             && ({1'b0, credit_q} >= PRICE5)) begin
                    credit_d   = credit_q - PRICE5[3:0];
                    dispense_d = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                reject_d = bus.coin_valid;
                cnt_d    = cnt_q + 8'd1;
                if (bus.disp_ack) begin
                    dispense_d = 1'b0;
                    state_d    = (credit_q != 4'd0) ? S_CHANGE : S_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    // Motor never answered: give the price back so it is paid out as change.
                    dispense_d = 1'b0;
                    fault_d    = 1'b1;
                    credit_d   = credit_q + PRICE5[3:0];
                    state_d    = S_CHANGE;
                end
            end
            S_CHANGE: begin
                reject_d = bus.coin_valid;
                if (!phase_q) begin
                    if (credit_q != 4'd0) begin
                        change_d = 1'b1;
                        credit_d = credit_q - 4'd1;
                        phase_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (credit_q == 4'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            credit_q   <= 4'd0;
            cnt_q      <= 8'd0;
            phase_q    <= 1'b0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            dispense_q <= dispense_d;
            change_q   <= change_d;
            reject_q   <= reject_d;
            fault_q    <= fault_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.credit_state = credit_q;
    assign bus.dispense     = dispense_q;
    assign bus.change_pulse = change_q;
    assign bus.coin_reject  = reject_q;
    assign bus.fault        = fault_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vend_credit_sequencer.sv
// tb/tb_vend_credit_sequencer.sv - self-checking bench for vend_credit_sequencer
module tb_vend_credit_sequencer;
    localparam int PRICE       = 3;
    localparam int MAX_CREDIT  = 15;
    localparam int ACK_TIMEOUT = 16;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    vend_credit_sequencer_if bus ();

    vend_credit_sequencer #(
        .PRICE       (PRICE),
        .MAX_CREDIT  (MAX_CREDIT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Reference model: machine mode, credit as a plain integer, and what each output should be.
    typedef enum int {M_IDLE, M_COLLECT, M_DISP, M_CHANGE} mode_t;
    mode_t m_mode;
    int    m_credit;
    int    m_wait;
    bit    m_rest;
    bit    e_disp, e_chg, e_rej, e_fault;
    int    coin_units [4] = '{0, 1, 2, 5};

    function automatic bit e_busy();
        return (m_mode == M_DISP) || (m_mode == M_CHANGE);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_wait = 0; m_rest = 0;
        e_disp = 0; e_chg = 0; e_rej = 0; e_fault = 0;
    endtask

    task automatic model_step(input bit cv, input int val, input bit vr, input bit cn, input bit ack);
        int add;
        add = coin_units[val];
        e_chg = 0; e_rej = 0; e_fault = 0;
        if (m_mode == M_IDLE || m_mode == M_COLLECT) begin
            if (m_mode == M_COLLECT && cn) begin
                e_rej = cv; m_mode = M_CHANGE; m_rest = 0;
            end else if (cv) begin
                if (add > 0 && m_credit + add <= MAX_CREDIT) begin
                    m_credit += add; m_mode = M_COLLECT;
                end else e_rej = 1;
            end else if (m_mode == M_COLLECT && vr && m_credit >= PRICE) begin
                m_credit -= PRICE; e_disp = 1; m_wait = 0; m_mode = M_DISP;
            end
        end else if (m_mode == M_DISP) begin
            e_rej = cv;
            m_wait++;
            if (ack) begin
                e_disp = 0; m_rest = 0;
                m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
            end else if (m_wait == ACK_TIMEOUT) begin
                e_disp = 0; e_fault = 1; m_credit += PRICE; m_rest = 0; m_mode = M_CHANGE;
            end
        end else begin
            e_rej = cv;
            if (m_rest) begin
                m_rest = 0;
                if (m_credit == 0) m_mode = M_IDLE;
            end else if (m_credit > 0) begin
                e_chg = 1; m_credit--; m_rest = 1;
            end else m_mode = M_IDLE;
        end
    endtask

    task automatic step(input bit cv, input logic [1:0] val, input bit vr, input bit cn, input bit ack);
        @(negedge clk);
        bus.coin_valid = cv; bus.coin_value = val; bus.vend_req = vr;
        bus.cancel = cn; bus.disp_ack = ack;
        @(posedge clk);
        model_step(cv, int'(val), vr, cn, ack);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.coin_valid = 0; bus.coin_value = 0; bus.vend_req = 0; bus.cancel = 0; bus.disp_ack = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [8:0] outs();
        return {bus.credit_state, bus.dispense, bus.change_pulse, bus.coin_reject, bus.fault, bus.busy};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs() !== 9'd0) begin
            errors++; $display("FAIL reset_state: actual=%b required=%b", outs(), 9'd0);
        end
    endtask

    task automatic test_coins();
        do_reset();
        step(1, 2'b01, 0, 0, 0);
        checks++;
        if (bus.credit_state !== 4'd1 || bus.coin_reject !== 1'b0) begin
            errors++; $display("FAIL coin_01: actual credit=%0d rej=%b required credit=1 rej=0", bus.credit_state, bus.coin_reject);
        end
        step(1, 2'b10, 0, 0, 0);
        checks++;
        if (bus.credit_state !== 4'd3 || bus.coin_reject !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL coin_10: actual credit=%0d rej=%b busy=%b required credit=3 rej=0 busy=0", bus.credit_state, bus.coin_reject, bus.busy);
        end
    endtask

    task automatic test_vend_exact();
        int pulses;
        step(0, 2'b00, 1, 0, 0);
        checks++;
        if (bus.credit_state !== 4'd0 || bus.dispense !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL vend_exact: actual credit=%0d disp=%b busy=%b required credit=0 disp=1 busy=1", bus.credit_state, bus.dispense, bus.busy);
        end
        repeat (3) step(0, 2'b00, 0, 0, 0);
        checks++;
        if (bus.dispense !== 1'b1) begin
            errors++; $display("FAIL vend_hold: actual disp=%b required disp=1", bus.dispense);
        end
        step(0, 2'b00, 0, 0, 1);
        checks++;
        if (bus.dispense !== 1'b0 || bus.busy !== 1'b0 || bus.fault !== 1'b0) begin
            errors++; $display("FAIL vend_ack: actual disp=%b busy=%b fault=%b required 0 0 0", bus.dispense, bus.busy, bus.fault);
        end
        pulses = 0;
        repeat (4) begin
            step(0, 2'b00, 0, 0, 0);
            if (bus.change_pulse) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL vend_no_change: actual pulses=%0d required=0", pulses);
        end
    endtask

    task automatic test_change();
        int pulses, last, n;
        int seq [4];
        do_reset();
        step(1, 2'b11, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        step(0, 2'b00, 1, 0, 0);
        step(0, 2'b00, 0, 0, 1);
        checks++;
        if (bus.credit_state !== 4'd4 || bus.dispense !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL change_entry: actual credit=%0d disp=%b busy=%b required credit=4 disp=0 busy=1", bus.credit_state, bus.dispense, bus.busy);
        end
        pulses = 0; last = -2; n = 0;
        for (int i = 0; i < 30 && bus.busy; i++) begin
            step(0, 2'b00, 0, 0, 0);
            n++;
            if (bus.change_pulse) begin
                if (pulses < 4) seq[pulses] = int'(bus.credit_state);
                checks++;
                if (pulses > 0 && n - last != 2) begin
                    errors++; $display("FAIL change_spacing: actual gap=%0d required=2", n - last);
                end
                last = n; pulses++;
            end
        end
        checks++;
        if (pulses != 4 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL change_count: actual pulses=%0d busy=%b required pulses=4 busy=0", pulses, bus.busy);
        end
        checks++;
        if (pulses == 4 && (seq[0] != 3 || seq[1] != 2 || seq[2] != 1 || seq[3] != 0)) begin
            errors++; $display("FAIL change_seq: actual %0d %0d %0d %0d required 3 2 1 0", seq[0], seq[1], seq[2], seq[3]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        step(1, 2'b11, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        checks++;
        if (bus.credit_state !== 4'd14 || bus.coin_reject !== 1'b1) begin
            errors++; $display("FAIL overflow_reject: actual credit=%0d rej=%b required credit=14 rej=1", bus.credit_state, bus.coin_reject);
        end
        step(1, 2'b01, 0, 0, 0);
        checks++;
        if (bus.credit_state !== 4'd15 || bus.coin_reject !== 1'b0) begin
            errors++; $display("FAIL fill_to_max: actual credit=%0d rej=%b required credit=15 rej=0", bus.credit_state, bus.coin_reject);
        end
        do_reset();
        step(1, 2'b00, 0, 0, 0);
        checks++;
        if (bus.credit_state !== 4'd0 || bus.coin_reject !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL coin_00: actual credit=%0d rej=%b busy=%b required 0 1 0", bus.credit_state, bus.coin_reject, bus.busy);
        end
        step(0, 2'b00, 0, 0, 0);
        checks++;
        if (bus.coin_reject !== 1'b0) begin
            errors++; $display("FAIL reject_one_cycle: actual rej=%b required 0", bus.coin_reject);
        end
    endtask

    task automatic test_timeout();
        int high, faults, pulses;
        do_reset();
        step(1, 2'b11, 0, 0, 0);
        step(0, 2'b00, 1, 0, 0);
        high = 0; faults = 0;
        for (int i = 0; i < 40 && bus.dispense; i++) begin
            high++;
            step(0, 2'b00, 0, 0, 0);
            if (bus.fault) faults++;
        end
        checks++;
        if (high != ACK_TIMEOUT || faults != 1 || bus.credit_state !== 4'd5) begin
            errors++; $display("FAIL timeout: actual high=%0d faults=%0d credit=%0d required high=16 faults=1 credit=5", high, faults, bus.credit_state);
        end
        pulses = 0;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            step(0, 2'b00, 0, 0, 0);
            if (bus.change_pulse) pulses++;
            if (bus.fault) faults++;
        end
        checks++;
        if (pulses != 5 || faults != 1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL timeout_refund: actual pulses=%0d faults=%0d busy=%b required 5 1 0", pulses, faults, bus.busy);
        end
    endtask

    task automatic test_cancel();
        int pulses;
        do_reset();
        step(1, 2'b10, 0, 0, 0);
        step(1, 2'b01, 0, 1, 0);
        checks++;
        if (bus.coin_reject !== 1'b1 || bus.credit_state !== 4'd2 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL cancel_coin: actual rej=%b credit=%0d busy=%b required 1 2 1", bus.coin_reject, bus.credit_state, bus.busy);
        end
        pulses = 0;
        for (int i = 0; i < 20 && bus.busy; i++) begin
            step(0, 2'b00, 0, 0, 0);
            if (bus.change_pulse) pulses++;
        end
        checks++;
        if (pulses != 2 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL cancel_change: actual pulses=%0d busy=%b required 2 0", pulses, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 2'b11, 0, 0, 0);
        step(0, 2'b00, 0, 1, 0);
        step(0, 2'b00, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.credit_state !== 4'd0 || bus.change_pulse !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid: actual credit=%0d chg=%b busy=%b required 0 0 0", bus.credit_state, bus.change_pulse, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [8:0] exp;
        bit cv, vr, cn, ack;
        logic [1:0] val;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cv  = ($urandom_range(0, 2) == 0);
            val = 2'($urandom_range(0, 3));
            vr  = ($urandom_range(0, 2) == 0);
            cn  = ($urandom_range(0, 7) == 0);
            ack = ($urandom_range(0, 7) == 0);
            step(cv, val, vr, cn, ack);
            exp = {4'(m_credit), e_disp, e_chg, e_rej, e_fault, e_busy()};
            checks++;
            if (outs() !== exp) begin
                errors++; $display("FAIL random_cycle_%0d: actual {credit,disp,chg,rej,fault,busy}=%b required=%b", i, outs(), exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_coins();
        test_vend_exact();
        test_change();
        test_overflow();
        test_timeout();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vend_credit_sequencer.md
Name: vend_credit_sequencer

Overview:
- Sequential vending front end that owns the 4-bit machine state consumed by the downstream 4-to-2 state compressor.
- Accumulates coin credit and arbitrates vend and cancel requests.
- Runs a dispense handshake with the motor driver, then pays out change one unit at a time.
- Drives credit_state, the 4-bit value the compressor reduces to the 2-bit display/indicator state; any value of 4 or more reads as 0 downstream.

Parameters:
- PRICE, 3, item cost in credit units (1..MAX_CREDIT).
- MAX_CREDIT, 15, saturation ceiling for credit; must be at most 15.
- ACK_TIMEOUT, 16, cycles to wait for disp_ack before refunding (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- coin_valid  input  1  single-cycle coin strobe.
- coin_value  input  2  coin code: 00 = invalid, 01 = 1 unit, 10 = 2 units, 11 = 5 units.
- vend_req  input  1  purchase request (level; sampled each cycle).
- cancel  input  1  refund request (level).
- disp_ack  input  1  motor driver acknowledge.
- credit_state  output  4  current credit register.
- dispense  output  1  dispense request, held until ack or timeout.
- change_pulse  output  1  one-cycle pulse per unit of change returned.
- coin_reject  output  1  one-cycle pulse when a coin is refused.
- fault  output  1  one-cycle pulse on ack timeout.
- busy  output  1  high in DISPENSE and CHANGE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, credit_state 0, all pulse outputs 0, dispense 0, busy 0, timeout counter 0. Reset asserted mid-operation aborts immediately; no change is paid.
- FSM states: IDLE, COLLECT, DISPENSE, CHANGE. All outputs are registered; every effect appears the cycle after the triggering input sample.
- Coins, IDLE/COLLECT:
  - Valid code and credit + value <= MAX_CREDIT: credit += value; state goes to COLLECT.
  - Code 00, or sum > MAX_CREDIT: coin_reject pulses and credit is unchanged.
- Coins, DISPENSE/CHANGE: always rejected with a coin_reject pulse.
- Same-cycle priority in COLLECT: cancel > coin > vend_req.
  - Cancel with a coin: coin rejected, cancel taken.
  - Coin with vend_req: coin taken, vend_req re-evaluated next cycle.
- vend_req in COLLECT with credit >= PRICE: credit -= PRICE, dispense = 1, go to DISPENSE, timeout counter cleared. With credit < PRICE it is ignored and no state changes.
- cancel:
  - COLLECT: go to CHANGE.
  - IDLE: no effect.
  - DISPENSE: ignored.
- DISPENSE:
  - Counter increments every cycle.
  - disp_ack high: dispense drops next cycle; go to CHANGE if credit > 0, else IDLE.
  - Counter reaches ACK_TIMEOUT-1 without ack: dispense drops, fault pulses, credit += PRICE (restored), go to CHANGE.
  - Ack and timeout in the same cycle: ack wins; no fault.
- CHANGE:
  - change_pulse is asserted on alternating cycles (high, low, high, ...), starting the cycle after entry.
  - Each pulse decrements credit by 1 in the same cycle.
  - When credit reaches 0 after a pulse, go to IDLE on the following cycle.
  - Entry with credit 0 goes straight to IDLE with no pulse.
- busy = 1 exactly while in DISPENSE or CHANGE. While busy, vend_req and cancel are ignored.
- Arithmetic:
  - Addition is checked at 5 bits against MAX_CREDIT; credit never wraps.
  - Subtraction is guarded by the >= PRICE compare, so it never underflows.
- disp_ack outside DISPENSE is ignored.

Test Plan:
- Reset, then coins 01, 10 -> credit_state 1 then 3; state COLLECT; no rejects.
- Credit 3, vend_req -> credit_state 0, dispense = 1; ack after 4 cycles -> dispense drops next cycle; returns to IDLE with zero change_pulse.
- Coins 11, 10 (credit 7), vend_req, ack -> credit 4, then exactly 4 change_pulses spaced 2 cycles apart; credit_state sequence 4, 3, 2, 1, 0; then IDLE.
- Credit 14, coin 10 -> coin_reject pulse, credit stays 14. Coin 00 in IDLE -> coin_reject, credit 0, state IDLE.
- Credit 5, vend_req, no ack -> dispense high for 16 cycles, fault pulses once, credit restored to 5, then 5 change_pulses.
- Credit 2, cancel + coin 01 same cycle -> coin_reject, 2 change_pulses. rst_n low mid-CHANGE -> credit_state 0 immediately, change_pulse 0.
